// File: rtl/apb_timer_pkg.sv
// apb_timer_pkg: register offsets, CTRL/STATUS bit positions and APB FSM
// state encoding shared by the APB timer top and its counter core.
package apb_timer_pkg;

   // Register index (paddr[3:2]) within the 16-byte block at paddr[11:4]==0
   localparam logic [1:0] REG_CTRL   = 2'd0;
   localparam logic [1:0] REG_LOAD   = 2'd1;
   localparam logic [1:0] REG_COUNT  = 2'd2;
   localparam logic [1:0] REG_STATUS = 2'd3;

   localparam int CTRL_EN          = 0;
   localparam int CTRL_AUTO_RELOAD = 1;
   localparam int CTRL_IRQ_EN      = 2;
   localparam int STATUS_EXPIRED   = 0;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETUP,
      ST_WAIT,
      ST_DONE
   } state_e;

   // a holds paddr[11:2]; only the first 16 bytes are decoded
   function automatic logic addr_mapped(input logic [9:0] a);
      return a[9:2] == 8'd0;
   endfunction

endpackage

// File: rtl/apb_timer_core.sv
// apb_timer_core: 32-bit down counter with expiry detection and reload.
// Ports: en/auto_reload from CTRL, load_we/load_wdata for LOAD writes,
// load_val = LOAD register, count = COUNT, expire = expiry this cycle.
module apb_timer_core
   import apb_timer_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        en,
   input  logic        auto_reload,
   input  logic        load_we,
   input  logic [31:0] load_wdata,
   input  logic [31:0] load_val,
   output logic [31:0] count,
   output logic        expire
);

   logic [31:0] count_q, count_d;

   assign expire = en && (count_q == '0);
   assign count  = count_q;

   // A LOAD write beats decrement/reload; one-shot expiry holds 0
   always_comb begin
      count_d = count_q;
      if (load_we) begin
         count_d = load_wdata;
      end else if (en) begin
         if (count_q != '0) begin
            count_d = count_q - 32'd1;
         end else if (auto_reload) begin
            count_d = load_val;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) count_q <= '0;
      else        count_q <= count_d;
   end

endmodule

// File: rtl/apb_timer.sv
// apb_timer: APB slave with CTRL/LOAD/COUNT/STATUS timer registers.
// Ports: APB (psel, penable, pwrite, paddr, pwdata, prdata, pready), irq;
// pslverr only when APB_TIMER_PSLVERR_EN is defined.
module apb_timer
   import apb_timer_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        psel,
   input  logic        penable,
   input  logic        pwrite,
   input  logic [31:0] paddr,
   input  logic [31:0] pwdata,
   output logic [31:0] prdata,
   output logic        pready,
   output logic        irq
`ifdef APB_TIMER_PSLVERR_EN
   ,
   output logic        pslverr
`endif
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   state_e      state_q, state_d, cur_st;
   logic [3:0]  wcnt_q, wcnt_d;
   logic [9:0]  addr_q, addr_d;
   logic        wr_q, wr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [31:0] load_q, load_d;
   logic        expired_q, expired_d;

   logic [31:0] count, rdata;
   logic        expire, done, hit, bad, we;
   logic        we_ctrl, we_load, we_stat;
   logic        unused_paddr;

   assign unused_paddr = ^{paddr[31:12], paddr[1:0]};

   // The setup cycle is recognised combinationally so that the
   // registered state lines up with the access phase cycles.
   always_comb begin
      cur_st = state_q;
      if ((state_q == ST_IDLE || state_q == ST_DONE) && psel && !penable)
         cur_st = ST_SETUP;
      state_d = ST_IDLE;
      wcnt_d  = 4'd0;
      addr_d  = addr_q;
      wr_d    = wr_q;
      wdata_d = wdata_q;
      unique case (cur_st)
         ST_SETUP: begin
            addr_d  = paddr[11:2];
            wr_d    = pwrite;
            wdata_d = pwdata;
            if (WS == 4'd0) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_WAIT;
               wcnt_d  = 4'd1;
            end
         end
         ST_WAIT: begin
            if (psel) begin
               if (wcnt_q == WS) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_WAIT;
                  wcnt_d  = wcnt_q + 4'd1;
               end
            end
         end
         default: ;
      endcase
   end

   assign done    = state_q == ST_DONE;
   assign hit     = addr_mapped(addr_q);
   assign bad     = !hit || (wr_q && addr_q[1:0] == REG_COUNT);
   assign we      = done && wr_q && !bad;
   assign we_ctrl = we && addr_q[1:0] == REG_CTRL;
   assign we_load = we && addr_q[1:0] == REG_LOAD;
   assign we_stat = we && addr_q[1:0] == REG_STATUS;

   // CTRL write beats the one-shot EN clear; expiry beats W1C
   always_comb begin
      ctrl_d    = ctrl_q;
      load_d    = load_q;
      expired_d = expired_q;
      if (expire && !ctrl_q[CTRL_AUTO_RELOAD]) ctrl_d[CTRL_EN] = 1'b0;
      if (we_ctrl) ctrl_d = wdata_q[2:0];
      if (we_load) load_d = wdata_q;
      if (we_stat && wdata_q[STATUS_EXPIRED]) expired_d = 1'b0;
      if (expire) expired_d = 1'b1;
   end

   always_comb begin
      rdata = '0;
      if (hit) begin
         unique case (addr_q[1:0])
            REG_CTRL:   rdata = {29'd0, ctrl_q};
            REG_LOAD:   rdata = load_q;
            REG_COUNT:  rdata = count;
            REG_STATUS: rdata = {31'd0, expired_q};
         endcase
      end
   end

   assign prdata = (done && !wr_q) ? rdata : '0;
   assign pready = done;
   assign irq    = expired_q & ctrl_q[CTRL_IRQ_EN];
`ifdef APB_TIMER_PSLVERR_EN
   assign pslverr = done && bad;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         wcnt_q    <= '0;
         addr_q    <= '0;
         wr_q      <= 1'b0;
         wdata_q   <= '0;
         ctrl_q    <= '0;
         load_q    <= '0;
         expired_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wcnt_q    <= wcnt_d;
         addr_q    <= addr_d;
         wr_q      <= wr_d;
         wdata_q   <= wdata_d;
         ctrl_q    <= ctrl_d;
         load_q    <= load_d;
         expired_q <= expired_d;
      end
   end

   apb_timer_core u_core (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (ctrl_q[CTRL_EN]),
      .auto_reload (ctrl_q[CTRL_AUTO_RELOAD]),
      .load_we     (we_load),
      .load_wdata  (wdata_q),
      .load_val    (load_q),
      .count       (count),
      .expire      (expire)
   );

endmodule

// File: tb/tb_apb_timer.sv
// tb_apb_timer: randomized APB traffic against a register-level timer
// model; a monitor pops expected responses whenever pready is seen.
`timescale 1ns/1ps
module tb_apb_timer;

   localparam int WS = 3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        psel = 1'b0;
   logic        penable = 1'b0;
   logic        pwrite = 1'b0;
   logic [31:0] paddr = '0;
   logic [31:0] pwdata = '0;
   wire  [31:0] prdata;
   wire         pready;
   wire         irq;
`ifdef APB_TIMER_PSLVERR_EN
   wire         pslverr;
`endif

   apb_timer #(.WAIT_STATES(WS)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .psel    (psel),
      .penable (penable),
      .pwrite  (pwrite),
      .paddr   (paddr),
      .pwdata  (pwdata),
      .prdata  (prdata),
      .pready  (pready),
      .irq     (irq)
`ifdef APB_TIMER_PSLVERR_EN
      ,
      .pslverr (pslverr)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   // Register-level model of the timer
   logic        m_en = 0, m_ar = 0, m_ie = 0, m_exp = 0;
   logic [31:0] m_load = 0, m_count = 0;

   // Write committing at the next rising edge (driven by the driver only)
   logic        p_vld = 0;
   logic [1:0]  p_reg = 0;
   logic [31:0] p_data = 0;

   typedef struct {
      logic [31:0] rdata;
      logic        err;
   } exp_t;
   exp_t sb[$];
   logic exp_rdy = 1'b0;

   logic [31:0] addrs [8] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h40,
                              32'h10, 32'hFFFF_F004, 32'h802};

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a);
      if (a[11:4] != 8'd0) return 32'd0;
      case (a[3:2])
         2'd0:    return {29'd0, m_ie, m_ar, m_en};
         2'd1:    return m_load;
         2'd2:    return m_count;
         default: return {31'd0, m_exp};
      endcase
   endfunction

   function automatic logic m_err(input logic w, input logic [31:0] a);
      return (a[11:4] != 8'd0) || (w && a[3:2] == 2'd2);
   endfunction

   // Timer rules applied per clock: count down while enabled, expire at 0
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_en <= 0; m_ar <= 0; m_ie <= 0; m_exp <= 0;
         m_load <= 0; m_count <= 0;
      end else begin
         if (m_en)
            m_count <= (m_count != 0) ? m_count - 32'd1
                       : (m_ar ? m_load : 32'd0);
         if (m_en && m_count == 0 && !m_ar) m_en <= 1'b0;
         if (p_vld && p_reg == 2'd3 && p_data[0]) m_exp <= 1'b0;
         if (m_en && m_count == 0) m_exp <= 1'b1;
         if (p_vld && p_reg == 2'd0) {m_ie, m_ar, m_en} <= p_data[2:0];
         if (p_vld && p_reg == 2'd1) begin
            m_load  <= p_data;
            m_count <= p_data;
         end
      end
   end

   // Monitor
   always @(negedge clk) begin
      chk("pready", {31'd0, pready}, {31'd0, exp_rdy});
      chk("irq", {31'd0, irq}, {31'd0, m_exp & m_ie});
      if (pready) begin
         if (sb.size() == 0) begin
            chk("sb_unexpected", 32'd1, 32'd0);
         end else begin
            chk("prdata", prdata, sb[0].rdata);
`ifdef APB_TIMER_PSLVERR_EN
            chk("pslverr", {31'd0, pslverr}, {31'd0, sb[0].err});
`endif
            sb.delete(0);
         end
      end else begin
         chk("prdata_idle", prdata, 32'd0);
`ifdef APB_TIMER_PSLVERR_EN
         chk("pslverr_idle", {31'd0, pslverr}, 32'd0);
`endif
      end
   end

   // Called at posedge+1; returns at posedge+1 after the DONE cycle
   task automatic xfer(input logic wr, input logic [31:0] a,
                       input logic [31:0] d);
      exp_t e;
      psel = 1; penable = 0; pwrite = wr; paddr = a; pwdata = d;
      @(posedge clk); #1;
      penable = 1;
      paddr = $urandom; pwdata = $urandom; pwrite = 1'($urandom_range(0, 1));
      for (int i = 1; i <= WS + 1; i++) begin
         if (i == WS + 1) begin
            exp_rdy = 1;
            e.rdata = wr ? 32'd0 : m_read(a);
            e.err   = m_err(wr, a);
            sb.push_back(e);
            if (wr && !e.err) begin
               p_vld = 1; p_reg = a[3:2]; p_data = d;
            end
         end
         @(posedge clk); #1;
      end
      exp_rdy = 0; p_vld = 0;
      psel = 0; penable = 0;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk); #1;
      end
   endtask

   initial begin
      logic [31:0] a, d;
      logic        w;
      idle(3);
      rst_n = 1;
      idle(1);
      for (int i = 0; i < 4; i++) xfer(0, 32'(i * 4), 0);

      // auto-reload timer, LOAD=5
      xfer(1, 32'h4, 32'd5);
      xfer(1, 32'h0, 32'h7);
      for (int i = 0; i < 4; i++) xfer(0, 32'h8, 0);
      xfer(0, 32'hC, 0);

      // wait-state read of LOAD
      xfer(1, 32'h0, 32'h0);
      xfer(1, 32'h4, 32'hDEADBEEF);
      xfer(0, 32'h4, 0);
      idle(1);

      // one-shot
      xfer(1, 32'hC, 32'h1);
      xfer(1, 32'h4, 32'd2);
      xfer(1, 32'h0, 32'h1);
      idle(6);
      xfer(0, 32'h0, 0);
      xfer(0, 32'h8, 0);
      xfer(0, 32'hC, 0);

      // W1C racing expiry, then quiet clear
      xfer(1, 32'h4, 32'd3);
      xfer(1, 32'h0, 32'h7);
      for (int i = 0; i < 8; i++) xfer(1, 32'hC, 32'h1);
      xfer(1, 32'h0, 32'h4);
      xfer(1, 32'hC, 32'h1);
      xfer(0, 32'hC, 0);

      // error accesses
      xfer(1, 32'h8, 32'h1234);
      xfer(0, 32'h40, 0);
      xfer(0, 32'h8, 0);

      // randomized traffic
      for (int i = 0; i < 80; i++) begin
         a = addrs[$urandom_range(0, 7)];
         w = 1'($urandom_range(0, 1));
         case (a[3:2])
            2'd0:    d = 32'($urandom_range(0, 7));
            2'd1:    d = 32'($urandom_range(0, 12));
            default: d = $urandom;
         endcase
         xfer(w, a, d);
         idle($urandom_range(0, 2));
      end

      // reset in the middle of a LOAD write
      psel = 1; penable = 0; pwrite = 1; paddr = 32'h4; pwdata = 32'h10;
      @(posedge clk); #1;
      penable = 1;
      idle(1);
      rst_n = 0; psel = 0; penable = 0;
      idle(2);
      rst_n = 1;
      idle(1);
      xfer(0, 32'h4, 0);
      xfer(0, 32'h0, 0);
      idle(2);

      chk("sb_drain", 32'(sb.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
